// File: rtl/draw_pkg.sv
// Shared drawing definitions: mode encodings, default screen size,
// the 3-bit palette and the rectangle drawer state encoding.
package draw_pkg;

  localparam logic [1:0] MODE_FILL    = 2'b00;
  localparam logic [1:0] MODE_OUTLINE = 2'b01;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } draw_state_e;

  // Reserved mode codes fall back to fill, so only the exact outline code counts.
  function automatic logic is_outline(input logic [1:0] mode);
    return mode == MODE_OUTLINE;
  endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Column/row position counter for the rectangle scan. Presents the next
// position combinationally so the drawer can register the following pixel
// in the same cycle the current one is consumed.
module rect_scan_counter
  import draw_pkg::*;
#(
  parameter int SIZE_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [SIZE_W-1:0] w_i,
  input  logic [SIZE_W-1:0] h_i,
  input  logic              outline_i,
  output logic [SIZE_W-1:0] next_cx_o,
  output logic [SIZE_W-1:0] next_cy_o,
  output logic              last_o
);

  logic [SIZE_W-1:0] cx_q, cy_q;
  logic [SIZE_W-1:0] cx_d, cy_d;
  logic [SIZE_W-1:0] w_last, h_last;
  logic              row_end, interior_row;

  // Next position: wrap at row end, and in outline mode hop straight from
  // the left edge to the right edge on rows that are neither top nor bottom.
  always_comb begin
    w_last       = w_i - SIZE_W'(1);
    h_last       = h_i - SIZE_W'(1);
    row_end      = (cx_q == w_last);
    interior_row = (cy_q != '0) && (cy_q != h_last);
    cx_d         = cx_q + SIZE_W'(1);
    cy_d         = cy_q;
    if (row_end) begin
      cx_d = '0;
      cy_d = cy_q + SIZE_W'(1);
    end else if (outline_i && (cx_q == '0) && interior_row) begin
      cx_d = w_last;
    end
  end

  assign next_cx_o = cx_d;
  assign next_cy_o = cy_d;
  assign last_o    = row_end && (cy_q == h_last);

  // Position registers: cleared on a new rectangle, stepped when the drawer consumes a position.
  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (advance_i) begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/rect_drawer.sv
// Rectangle rasteriser for the frame-buffer plot path. Streams one pixel per
// accepted handshake in row-major order, supports fill and outline modes and
// drops pixels that fall off the screen.
//
// Plot handshake: plot_valid with x_out/y_out/c_out is held stable until the
// cycle plot_ready is high; the pixel transfers on that clock edge and the
// next candidate is loaded on the same edge. plot_ready is ignored while
// plot_valid is low.
module rect_drawer
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SIZE_W   = 5,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [SIZE_W-1:0] width,
  input  logic [SIZE_W-1:0] height,
  input  logic [C_W-1:0]    c_in,
  input  logic [1:0]        mode,
  input  logic              plot_ready,
  output logic              plot_valid,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [C_W-1:0]    c_out,
  output logic              busy,
  output logic              done
);

  localparam int XS = X_W + 1;
  localparam int YS = Y_W + 1;
  localparam logic [X_W:0] X_LIM = XS'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = YS'(SCREEN_H);

  draw_state_e       state_q;
  logic [X_W-1:0]    x0_q;
  logic [Y_W-1:0]    y0_q;
  logic [SIZE_W-1:0] w_q, h_q;
  logic              outline_q;
  logic              plot_valid_q, busy_q, done_q;
  logic [X_W-1:0]    x_out_q;
  logic [Y_W-1:0]    y_out_q;
  logic [C_W-1:0]    c_out_q;

  logic [SIZE_W-1:0] nxt_cx, nxt_cy;
  logic              last_pos;
  logic              accept_start, step, advance;

  logic [X_W-1:0]    cand_x0;
  logic [Y_W-1:0]    cand_y0;
  logic [SIZE_W-1:0] cand_cx, cand_cy, cand_w, cand_h;
  logic              cand_outline, cand_border, cand_vis;
  logic [X_W:0]      cand_x;
  logic [Y_W:0]      cand_y;

  assign accept_start = (state_q == ST_IDLE) && start;
  assign step         = (state_q == ST_SCAN) && (!plot_valid_q || plot_ready);
  assign advance      = step && !last_pos;

  rect_scan_counter #(
    .SIZE_W(SIZE_W)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (accept_start),
    .advance_i (advance),
    .w_i       (w_q),
    .h_i       (h_q),
    .outline_i (outline_q),
    .next_cx_o (nxt_cx),
    .next_cy_o (nxt_cy),
    .last_o    (last_pos)
  );

  // Candidate pixel to register next: the origin straight from the inputs when
  // starting, otherwise the counter's next position on the latched rectangle.
  // Sums carry one extra bit so wrap-around lands off screen.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cand_x0      = x_in;
      cand_y0      = y_in;
      cand_cx      = '0;
      cand_cy      = '0;
      cand_w       = width;
      cand_h       = height;
      cand_outline = is_outline(mode);
    end else begin
      cand_x0      = x0_q;
      cand_y0      = y0_q;
      cand_cx      = nxt_cx;
      cand_cy      = nxt_cy;
      cand_w       = w_q;
      cand_h       = h_q;
      cand_outline = outline_q;
    end
    cand_x      = {1'b0, cand_x0} + XS'(cand_cx);
    cand_y      = {1'b0, cand_y0} + YS'(cand_cy);
    cand_border = (cand_cx == '0) || (cand_cx == cand_w - SIZE_W'(1)) ||
                  (cand_cy == '0) || (cand_cy == cand_h - SIZE_W'(1));
    cand_vis    = (cand_x < X_LIM) && (cand_y < Y_LIM) &&
                  (cand_border || !cand_outline);
  end

  // Control FSM with registered pixel, busy and done outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      outline_q    <= 1'b0;
      plot_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      c_out_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            x0_q      <= x_in;
            y0_q      <= y_in;
            w_q       <= width;
            h_q       <= height;
            outline_q <= is_outline(mode);
            c_out_q   <= c_in;
            x_out_q   <= cand_x[X_W-1:0];
            y_out_q   <= cand_y[Y_W-1:0];
            busy_q    <= 1'b1;
            if ((width == '0) || (height == '0)) begin
              plot_valid_q <= 1'b0;
              state_q      <= ST_FIN;
            end else begin
              plot_valid_q <= cand_vis;
              state_q      <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (step) begin
            if (last_pos) begin
              plot_valid_q <= 1'b0;
              state_q      <= ST_FIN;
            end else begin
              plot_valid_q <= cand_vis;
              x_out_q      <= cand_x[X_W-1:0];
              y_out_q      <= cand_y[Y_W-1:0];
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign plot_valid = plot_valid_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign c_out      = c_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
